// File: rtl/alu_pkg.sv
// Shared op/func codes and FSM state for the multi-cycle ALU.
// Imported by alu_mc and alu_iter_unit.
package alu_pkg;

    localparam logic [2:0] OP_ARITH  = 3'b001;
    localparam logic [2:0] OP_UNARY  = 3'b010;
    localparam logic [2:0] OP_MULDIV = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;

    localparam logic [2:0] F_AND = 3'd0;
    localparam logic [2:0] F_OR  = 3'd1;
    localparam logic [2:0] F_XOR = 3'd2;
    localparam logic [2:0] F_BIC = 3'd3;
    localparam logic [2:0] F_ADD = 3'd4;
    localparam logic [2:0] F_ADC = 3'd5;
    localparam logic [2:0] F_SUB = 3'd6;
    localparam logic [2:0] F_SBC = 3'd7;

    localparam logic [2:0] F_NEG = 3'd0;
    localparam logic [2:0] F_NOT = 3'd1;
    localparam logic [2:0] F_SXT = 3'd2;
    localparam logic [2:0] F_SCL = 3'd3;

    localparam logic [2:0] F_SHL  = 3'd0;
    localparam logic [2:0] F_SHR  = 3'd1;
    localparam logic [2:0] F_SHRA = 3'd2;
    localparam logic [2:0] F_ROL  = 3'd3;
    localparam logic [2:0] F_ROR  = 3'd4;
    localparam logic [2:0] F_RCL  = 3'd5;
    localparam logic [2:0] F_RCR  = 3'd6;

    localparam logic [2:0] F_MUL  = 3'd0;
    localparam logic [2:0] F_DIVU = 3'd1;
    localparam logic [2:0] F_REMU = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Bit-serial shift/rotate, shift-add multiply and restoring divide.
// result/carry show the outcome of the step taken this cycle.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_type,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [SHW-1:0]   count,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH-1:0] acc, aux, bop;
    logic [WIDTH-1:0] acc_n, aux_n;
    logic [WIDTH:0]   sum, trial;
    logic [SHW-1:0]   cnt;
    logic [2:0]       op, fn;
    logic             cy, cy_n, busy;

    // acc: shift value / product high / remainder
    // aux: product low / dividend-then-quotient
    always_comb begin
        acc_n = acc;
        aux_n = aux;
        cy_n  = cy;
        sum   = {1'b0, acc} + (aux[0] ? {1'b0, bop} : '0);
        trial = {acc, aux[WIDTH-1]} - {1'b0, bop};
        if (op == OP_SHIFT) begin
            unique case (fn)
                F_SHL: begin
                    acc_n = {acc[WIDTH-2:0], 1'b0};
                    cy_n  = acc[WIDTH-1];
                end
                F_SHR: begin
                    acc_n = {1'b0, acc[WIDTH-1:1]};
                    cy_n  = acc[0];
                end
                F_SHRA: begin
                    acc_n = {acc[WIDTH-1], acc[WIDTH-1:1]};
                    cy_n  = acc[0];
                end
                F_ROL: begin
                    acc_n = {acc[WIDTH-2:0], acc[WIDTH-1]};
                    cy_n  = acc[WIDTH-1];
                end
                F_ROR: begin
                    acc_n = {acc[0], acc[WIDTH-1:1]};
                    cy_n  = acc[0];
                end
                F_RCL: begin
                    acc_n = {acc[WIDTH-2:0], cy};
                    cy_n  = acc[WIDTH-1];
                end
                F_RCR: begin
                    acc_n = {cy, acc[WIDTH-1:1]};
                    cy_n  = acc[0];
                end
                default: ;
            endcase
        end else if (fn == F_MUL) begin
            acc_n = sum[WIDTH:1];
            aux_n = {sum[0], aux[WIDTH-1:1]};
        end else if (trial[WIDTH] && (bop != '0)) begin
            acc_n = {acc[WIDTH-2:0], aux[WIDTH-1]};
            aux_n = {aux[WIDTH-2:0], 1'b0};
        end else begin
            // a zero divisor always "subtracts": all-ones quotient, remainder = A
            acc_n = trial[WIDTH-1:0];
            aux_n = {aux[WIDTH-2:0], 1'b1};
        end
    end

    assign done = busy && (cnt == '0);

    always_comb begin
        result = aux_n;
        carry  = 1'b0;
        if (op == OP_SHIFT) begin
            result = acc_n;
            carry  = cy_n;
        end else if (fn == F_MUL) begin
            carry = |acc_n;
        end else if (fn == F_REMU) begin
            result = acc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            aux  <= '0;
            bop  <= '0;
            cy   <= 1'b0;
            op   <= '0;
            fn   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            op   <= op_type;
            fn   <= func;
            bop  <= b;
            cy   <= cin;
            if (op_type == OP_SHIFT) begin
                acc <= a;
                aux <= '0;
                cnt <= count;
            end else begin
                acc <= '0;
                aux <= a;
                cnt <= SHW'(WIDTH - 1);
            end
        end else if (busy) begin
            acc <= acc_n;
            aux <= aux_n;
            cy  <= cy_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshake FSM, single-cycle ops and flag generation.
// Shifts, multiply and divide run in alu_iter_unit.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       op_type,
    input  logic [2:0]       func,
    input  logic [SHW-1:0]   shift_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic [3:0]       CVZN
);

    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] sres, addend, it_result;
    logic [WIDTH:0]   sum, neg;
    logic             sc, sv, sok, itok, cyi;
    logic             it_start, it_done, it_carry, div0;

    assign in_ready = (state == ST_IDLE) && !rst;
    assign it_start = in_ready && in_valid && itok;

    always_comb begin
        sres   = '0;
        sc     = 1'b0;
        sv     = 1'b0;
        sok    = 1'b0;
        itok   = 1'b0;
        addend = ((func == F_SUB) || (func == F_SBC)) ? ~B : B;
        cyi    = (func == F_SUB) ? 1'b1 : ((func == F_ADD) ? 1'b0 : Cin);
        sum    = {1'b0, A} + {1'b0, addend} + {{WIDTH{1'b0}}, cyi};
        neg    = {1'b0, ~A} + {{WIDTH{1'b0}}, 1'b1};
        unique case (op_type)
            OP_ARITH: begin
                sok = 1'b1;
                unique case (func)
                    F_AND:   sres = A & B;
                    F_OR:    sres = A | B;
                    F_XOR:   sres = A ^ B;
                    F_BIC:   sres = A & ~B;
                    default: begin
                        sres = sum[WIDTH-1:0];
                        sc   = sum[WIDTH];
                        sv   = (A[WIDTH-1] == addend[WIDTH-1]) &&
                               (sum[WIDTH-1] != A[WIDTH-1]);
                    end
                endcase
            end
            OP_UNARY: begin
                unique case (func)
                    F_NEG: begin
                        sok  = 1'b1;
                        sres = neg[WIDTH-1:0];
                        sc   = neg[WIDTH];
                        sv   = (A == MINV);
                    end
                    F_NOT: begin
                        sok  = 1'b1;
                        sres = ~A;
                    end
                    F_SXT: begin
                        sok  = 1'b1;
                        sres = {{(WIDTH-8){A[7]}}, A[7:0]};
                    end
                    F_SCL: begin
                        sok  = 1'b1;
                        sres = {{(WIDTH-8){1'b0}}, A[7:0]};
                    end
                    default: ;
                endcase
            end
            OP_SHIFT:  itok = (func <= F_RCR);
            OP_MULDIV: itok = (func <= F_REMU);
            default: ;
        endcase
    end

    alu_iter_unit #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (it_start),
        .op_type(op_type),
        .func   (func),
        .a      (A),
        .b      (B),
        .cin    (Cin),
        .count  (shift_count),
        .done   (it_done),
        .result (it_result),
        .carry  (it_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            S         <= '0;
            CVZN      <= '0;
            div0      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        div0 <= (op_type == OP_MULDIV) &&
                                (func != F_MUL) && (B == '0);
                        if (itok) begin
                            state <= ST_EXEC;
                        end else begin
                            // unlisted codes finish here with S and flags zero
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            if (sok) begin
                                S    <= sres;
                                CVZN <= {sc, sv, sres == '0,
                                         sres[WIDTH-1]};
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    if (it_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        S         <= it_result;
                        CVZN      <= {it_carry, div0, it_result == '0,
                                      it_result[WIDTH-1]};
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        S         <= '0;
                        CVZN      <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, Cin, out_valid, out_ready;
    logic [15:0] A, B, S;
    logic [2:0]  op_type, func;
    logic [3:0]  shift_count, CVZN;
    int          checks = 0;
    int          errors = 0;
    int          seen;

    alu_mc #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .Cin        (Cin),
        .op_type    (op_type),
        .func       (func),
        .shift_count(shift_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .S          (S),
        .CVZN       (CVZN)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] fn,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [3:0] sc);
        int n;
        @(negedge clk);
        op_type = op; func = fn; A = a; B = b;
        Cin = ci; shift_count = sc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " clear"}, 64'({out_valid, S, CVZN}), 64'(0));
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [2:0] fn, input logic [15:0] a,
                       input logic [15:0] b, input logic ci,
                       input logic [3:0] sc, input logic [15:0] es,
                       input logic [3:0] ef, input int elat);
        int lat;
        send(op, fn, a, b, ci, sc);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " valid"}, 64'(out_valid), 64'(1));
        chk({tag, " lat"}, 64'(lat), 64'(elat));
        chk({tag, " S"}, 64'(S), 64'(es));
        chk({tag, " CVZN"}, 64'(CVZN), 64'(ef));
        take(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        op_type = '0; func = '0; shift_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 64'(in_ready), 64'(0));
        chk("rst outs", 64'({out_valid, S, CVZN}), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst in_ready", 64'(in_ready), 64'(1));

        run("ADD", OP_ARITH, F_ADD, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 4'b0101, 0);
        run("ADC", OP_ARITH, F_ADC, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 4'b1010, 0);
        run("SBC", OP_ARITH, F_SBC, 16'h8000, 16'h0001, 1, 0, 16'h7FFF, 4'b1100, 0);
        run("BIC", OP_ARITH, F_BIC, 16'hFFFF, 16'h00F0, 0, 0, 16'hFF0F, 4'b0001, 0);
        run("NEG", OP_UNARY, F_NEG, 16'h8000, 16'h0000, 0, 0, 16'h8000, 4'b0101, 0);
        run("SXT", OP_UNARY, F_SXT, 16'h1280, 16'h0000, 0, 0, 16'hFF80, 4'b0001, 0);
        run("SCL", OP_UNARY, F_SCL, 16'hABCD, 16'h0000, 0, 0, 16'h00CD, 4'b0000, 0);
        run("SHL", OP_SHIFT, F_SHL, 16'h1001, 16'h0000, 0, 3, 16'h0010, 4'b1000, 4);
        run("SHRA", OP_SHIFT, F_SHRA, 16'h8000, 16'h0000, 0, 3, 16'hF800, 4'b0001, 4);
        run("ROL", OP_SHIFT, F_ROL, 16'h8001, 16'h0000, 0, 1, 16'h0006, 4'b0000, 2);
        run("RCR", OP_SHIFT, F_RCR, 16'h0001, 16'h0000, 1, 0, 16'h8000, 4'b1001, 1);
        run("MUL", OP_MULDIV, F_MUL, 16'h0100, 16'h0100, 0, 0, 16'h0000, 4'b1010, 16);
        run("DIVU", OP_MULDIV, F_DIVU, 16'd100, 16'd7, 0, 0, 16'h000E, 4'b0000, 16);
        run("REMU", OP_MULDIV, F_REMU, 16'd100, 16'd7, 0, 0, 16'h0002, 4'b0000, 16);
        run("DIV0", OP_MULDIV, F_DIVU, 16'h1234, 16'h0000, 0, 0, 16'hFFFF, 4'b0101, 16);
        run("REM0", OP_MULDIV, F_REMU, 16'h1234, 16'h0000, 0, 0, 16'h1234, 4'b0100, 16);
        run("BAD op0", 3'b000, 3'd0, 16'h1234, 16'h5678, 0, 0, 16'h0000, 4'b0000, 0);
        run("BAD un5", OP_UNARY, 3'd5, 16'h1234, 16'h5678, 0, 0, 16'h0000, 4'b0000, 0);
        run("BAD sh7", OP_SHIFT, 3'd7, 16'h1234, 16'h5678, 0, 2, 16'h0000, 4'b0000, 0);

        send(OP_ARITH, F_ADD, 16'h0003, 16'h0004, 0, 0);
        chk("bp valid", 64'(out_valid), 64'(1));
        @(negedge clk);
        op_type = OP_ARITH; func = F_XOR;
        A = 16'hFF00; B = 16'h0F0F; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp hold S", 64'(S), 64'(16'h0007));
            chk("bp hold CVZN", 64'(CVZN), 64'(0));
            chk("bp in_ready", 64'(in_ready), 64'(0));
            chk("bp out_valid", 64'(out_valid), 64'(1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp handoff no accept", 64'(out_valid), 64'(0));
        chk("bp handoff in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp next valid", 64'(out_valid), 64'(1));
        chk("bp next S", 64'(S), 64'(16'hF00F));
        chk("bp next CVZN", 64'(CVZN), 64'(4'b0001));
        take("bp next");

        send(OP_MULDIV, F_MUL, 16'h0003, 16'h0005, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort rst in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort post in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("abort no out_valid", 64'(seen), 64'(0));
        run("SUB", OP_ARITH, F_SUB, 16'h0005, 16'h0007, 0, 0, 16'hFFFE, 4'b0001, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
